// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix scan controller.
// Holds the scan FSM state type, the matrix geometry and the mapping
// from the three column groups onto the five physical column enables.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam int ROWS      = 7;
  localparam int GROUPS    = 3;
  localparam int PHYS_COLS = 5;

  // Group index the scan starts each frame with
  localparam logic [1:0] GROUP_FIRST = 2'd2;

  // Physical columns driven by each group: group 2 -> cols 0 & 4,
  // group 1 -> cols 1 & 3, group 0 -> col 2 (mirror-symmetric layout)
  localparam logic [GROUPS-1:0][PHYS_COLS-1:0] GROUP_COL_MAP = {
    5'b10001,
    5'b01010,
    5'b00100
  };

  // Expand a group strobe vector into physical column enables
  function automatic logic [PHYS_COLS-1:0] groupsToColumns(input logic [GROUPS-1:0] strobe);
    logic [PHYS_COLS-1:0] cols;
    cols = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (strobe[g]) begin
        cols = cols | GROUP_COL_MAP[g];
      end
    end
    return cols;
  endfunction

endpackage

// File: rtl/matrix_pattern_buffer.sv
// Double-buffered pattern store for the scan controller.
// A shadow register accepts new patterns over valid/ready; the active
// register feeding the driver is only replaced when the scan FSM signals a
// frame boundary, so a frame is never drawn with a mix of two patterns.
// After a promotion the shadow reports empty one cycle after the
// frame-start cycle, so a pattern held by the producer is taken on the
// edge that ends that cycle.
module matrix_pattern_buffer
  import matrix_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            i_promote,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [ROWS-1:0] i_pat2,
  input  logic [ROWS-1:0] i_pat1,
  input  logic [ROWS-1:0] i_pat0,
  output logic [ROWS-1:0] o_col2,
  output logic [ROWS-1:0] o_col1,
  output logic [ROWS-1:0] o_col0
);

  logic [3*ROWS-1:0] r_shadow;
  logic [3*ROWS-1:0] r_active;
  logic              r_full;
  logic              r_clearPending;

  assign o_ready = ~r_full;
  assign o_col2  = r_active[3*ROWS-1:2*ROWS];
  assign o_col1  = r_active[2*ROWS-1:ROWS];
  assign o_col0  = r_active[ROWS-1:0];

  // Capture offered patterns into the shadow and promote them at frame boundaries
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shadow       <= '0;
      r_active       <= '0;
      r_full         <= 1'b0;
      r_clearPending <= 1'b0;
    end else begin
      r_clearPending <= 1'b0;
      if (r_clearPending) begin
        r_full <= 1'b0;
      end
      if (i_promote && r_full && !r_clearPending) begin
        r_active       <= r_shadow;
        r_clearPending <= 1'b1;
      end
      if (i_valid && !r_full) begin
        r_shadow <= {i_pat2, i_pat1, i_pat0};
        r_full   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_scan_controller.sv
// Time-multiplexed scan sequencer for the 7-row LED matrix driver.
// Walks column groups 2 -> 1 -> 0, each preceded by a blanking gap with all
// strobes low, and swaps in newly offered patterns only at frame starts.
// Optional build macro SCAN_BRIGHTNESS_EN adds a 4-bit brightness input that
// shortens the strobe within each dwell in sixteenths.
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [3:0]           brightness,
`endif
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [ROWS-1:0]      pat_col_2,
  input  logic [ROWS-1:0]      pat_col_1,
  input  logic [ROWS-1:0]      pat_col_0,
  output logic [ROWS-1:0]      col_2,
  output logic [ROWS-1:0]      col_1,
  output logic [ROWS-1:0]      col_0,
  output logic [GROUPS-1:0]    ring_counter,
  output logic [PHYS_COLS-1:0] column_sel,
  output logic                 frame_start
);

  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

  scan_state_t       r_state;
  logic [1:0]        r_group;
  logic [CNT_W-1:0]  r_cnt;
  logic [GROUPS-1:0] r_ring;
  logic              r_frameStart;

  scan_state_t       w_stateNext;
  logic [1:0]        w_groupNext;
  logic [CNT_W-1:0]  w_cntNext;
  logic              w_boundary;
  logic              w_strobeOn;
  logic [GROUPS-1:0] w_ringNext;

  // Next phase of the scan: state, group, phase counter and frame boundary
  always_comb begin
    w_stateNext = r_state;
    w_groupNext = r_group;
    w_cntNext   = r_cnt;
    w_boundary  = 1'b0;
    if (!enable) begin
      w_stateNext = ST_IDLE;
      w_groupNext = GROUP_FIRST;
      w_cntNext   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_boundary  = 1'b1;
          w_groupNext = GROUP_FIRST;
          w_cntNext   = '0;
          w_stateNext = HAS_BLANK ? ST_BLANK : ST_SHOW;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_stateNext = ST_SHOW;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_cntNext   = '0;
            w_groupNext = (r_group == 2'd0) ? GROUP_FIRST : r_group - 2'd1;
            w_boundary  = (r_group == 2'd0);
            w_stateNext = HAS_BLANK ? ST_BLANK : ST_SHOW;
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_groupNext = GROUP_FIRST;
          w_cntNext   = '0;
        end
      endcase
    end
  end

`ifdef SCAN_BRIGHTNESS_EN
  localparam logic [CNT_W+4:0] SLICE = (CNT_W+5)'(DWELL_CYCLES / 16);

  logic [3:0]       r_bright;
  logic [3:0]       w_brightEff;
  logic [CNT_W+4:0] w_onCycles;

  assign w_brightEff = w_boundary ? brightness : r_bright;
  assign w_onCycles  = ({{(CNT_W+1){1'b0}}, w_brightEff} + (CNT_W+5)'(1)) * SLICE;
  assign w_strobeOn  = ({5'b00000, w_cntNext} < w_onCycles);

  // Hold the brightness level sampled at the frame boundary for the whole frame
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bright <= 4'd0;
    end else if (w_boundary) begin
      r_bright <= brightness;
    end
  end
`else
  assign w_strobeOn = 1'b1;
`endif

  assign w_ringNext = (w_stateNext == ST_SHOW && w_strobeOn) ? (GROUPS'(1) << w_groupNext) : '0;

  // Advance the scan and register the strobe and frame-start outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_group      <= GROUP_FIRST;
      r_cnt        <= '0;
      r_ring       <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_group      <= w_groupNext;
      r_cnt        <= w_cntNext;
      r_ring       <= w_ringNext;
      r_frameStart <= w_boundary;
    end
  end

  assign ring_counter = r_ring;
  assign column_sel   = groupsToColumns(r_ring);
  assign frame_start  = r_frameStart;

  matrix_pattern_buffer u_buffer (
    .clock     (clock),
    .reset     (reset),
    .i_promote (w_boundary),
    .i_valid   (frame_valid),
    .o_ready   (frame_ready),
    .i_pat2    (pat_col_2),
    .i_pat1    (pat_col_1),
    .i_pat0    (pat_col_0),
    .o_col2    (col_2),
    .o_col1    (col_1),
    .o_col0    (col_0)
  );

endmodule

// File: doc/matrix_scan_controller.md
Name: matrix_scan_controller

Overview:
- Time-multiplexed scan sequencer for the 7-row LED matrix driver.
- Generates the one-hot column-group strobe (ring_counter) and the physical column enables, with dead-time blanking between groups to prevent ghosting.
- Holds the displayed 3x7 pattern in an active register.
- Accepts new patterns over a valid/ready handshake into a shadow register; shadow is promoted to active only at frame boundaries (tear-free).

Parameters:
- DWELL_CYCLES, 1000, clock cycles each column group is shown; >=1; multiple of 16 when SCAN_BRIGHTNESS_EN is defined.
- BLANK_CYCLES, 16, dead-time cycles before each group with all strobes low; 0 = no blanking.
- CNT_W, 16, width of the internal phase counter; must hold max(DWELL_CYCLES, BLANK_CYCLES)-1.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  scan run; low forces IDLE.
- frame_valid  in  1  new pattern offered.
- frame_ready  out  1  shadow register empty, pattern accepted when valid&&ready.
- pat_col_2  in  7  new pattern, columns 0 & 4 (bit 6 = row_0).
- pat_col_1  in  7  new pattern, columns 1 & 3.
- pat_col_0  in  7  new pattern, column 2.
- col_2  out  7  active pattern to driver, group 2.
- col_1  out  7  active pattern to driver, group 1.
- col_0  out  7  active pattern to driver, group 0.
- ring_counter  out  3  one-hot group strobe to driver; 000 during blank/idle.
- column_sel  out  5  physical column enables; [0]=[4]=ring_counter[2], [1]=[3]=ring_counter[1], [2]=ring_counter[0].
- frame_start  out  1  one-cycle pulse on first cycle of each frame.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: ring_counter=000, column_sel=00000, col_*=0, shadow empty, frame_ready=1, frame_start=0, FSM=IDLE, group=2, counter=0.
- States: IDLE, BLANK, SHOW. Registered group index cycles 2 -> 1 -> 0 -> 2.
- IDLE -> BLANK(group 2) when enable=1, or -> SHOW if BLANK_CYCLES=0.
- BLANK: ring_counter=000 for BLANK_CYCLES cycles, then SHOW.
- SHOW: ring_counter=one-hot(group) for DWELL_CYCLES cycles. At the end, group advances and state -> BLANK (or SHOW if BLANK_CYCLES=0).
- Frame period = 3*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Frame boundary = the edge that enters group 2's first phase, including the edge leaving IDLE.
  - frame_start=1 for exactly that first cycle.
  - If the shadow is full, shadow -> col_* on that edge, so new data is visible in the frame_start cycle. Shadow becomes empty and frame_ready=1 from the following cycle.
- Handshake:
  - Capture pat_* into shadow on edge where frame_valid&&frame_ready; frame_ready=0 next cycle.
  - Offered data held while ready=0; valid may drop without penalty.
  - Capture in the frame_start cycle: data goes to shadow, shown the following frame (at most one frame of latency beyond the current one).
- enable deasserted in any state: next cycle IDLE, ring_counter=000, counter=0, group=2. Active pattern and shadow are retained; handshake stays live.
- ring_counter is registered. Never more than one bit high. Never two different groups in consecutive cycles when BLANK_CYCLES>=1.
- Counter compare is against the parameter minus 1. No wrap beyond the terminal count.

Optional Feature:
- Macro SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input brightness[3:0].
  - In SHOW, ring_counter is asserted only for the first (brightness+1)*(DWELL_CYCLES/16) cycles, then 000 for the remainder of the dwell.
  - brightness is sampled at frame_start and held for the frame.
  - Frame timing is unchanged.
- Without it: no port; strobe is asserted for the full dwell.

Decomposition:
- Package matrix_pkg:
  - scan_state_t enum (IDLE, BLANK, SHOW).
  - Constants ROWS=7, GROUPS=3, PHYS_COLS=5.
  - group-to-column mapping constant.
- Sub-module matrix_pattern_buffer: shadow/active registers plus the valid/ready logic, with a promote strobe input from the FSM.

Test Plan:
- DWELL=4, BLANK=2, reset, enable=1:
  - ring_counter sequence is 000x2, 100x4, 000x2, 010x4, 000x2, 001x4, repeating.
  - frame_start every 18 cycles.
  - column_sel=10001 during 100.
- Offer pattern A (col_2=7'h7F, col_1=7'h41, col_0=7'h08) mid-frame:
  - accepted in 1 cycle, frame_ready low.
  - col_* update exactly in the next frame_start cycle.
  - frame_ready high the cycle after.
- Offer B while shadow holds A: valid held and ready=0 until promotion; B is shown one frame after A.
- Drop enable during the group-1 SHOW: ring_counter=000 next cycle. Re-enable: frame_start on the first cycle back, group 2 BLANK.
- Assert reset during SHOW with shadow full:
  - next cycle all outputs at reset values, col_*=0, frame_ready=1.
- BLANK=0: strobes switch 100 -> 010 -> 001 back-to-back. With SCAN_BRIGHTNESS_EN, DWELL=16, brightness=3: strobe high 4 of 16 cycles per group.
